// File: rtl/ov7670_dvp_pkg.sv
`default_nettype none
// Shared definitions for the OV7670 DVP emulator.
// Contents: FSM state encoding, RGB565 colour-bar constants and small helpers.
package ov7670_dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } dvp_state_e;

  localparam logic [15:0] C_BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] C_BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] C_BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] C_BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] C_BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] C_BAR_RED     = 16'hF800;
  localparam logic [15:0] C_BAR_BLUE    = 16'h001F;
  localparam logic [15:0] C_BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = C_BAR_WHITE;
      3'd1:    c = C_BAR_YELLOW;
      3'd2:    c = C_BAR_CYAN;
      3'd3:    c = C_BAR_GREEN;
      3'd4:    c = C_BAR_MAGENTA;
      3'd5:    c = C_BAR_RED;
      3'd6:    c = C_BAR_BLUE;
      default: c = C_BAR_BLACK;
    endcase
    return c;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ov7670_dvp_emulator_pattern.sv
`default_nettype none
// dvp_pattern_gen: combinational test-pattern source, (x, y, sel) -> RGB565 pixel.
module dvp_pattern_gen
  import ov7670_dvp_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9
) (
  input  logic [X_W-1:0] x_i,
  input  logic [Y_W-1:0] y_i,
  input  logic           sel_i,
  output logic [15:0]    pix_o
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [2:0] w_bar;

  assign w_bar = 3'(x_i / X_W'(BAR_W));

  always_comb begin
    pix_o = bar_colour(w_bar);
    if (sel_i) begin
      pix_o = {8'(y_i), 8'(x_i)};
    end
  end

endmodule
`default_nettype wire

// File: rtl/ov7670_dvp_emulator.sv
`default_nettype none
// ov7670_dvp_emulator: sensor-side OV7670 DVP source (PCLK/VSYNC/HREF/DATA)
// with a built-in colour-bar / coordinate test pattern.
module ov7670_dvp_emulator
  import ov7670_dvp_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned H_BLANK       = 288,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned VSYNC_LINES   = 3,
  parameter int unsigned V_BACK_LINES  = 17,
  parameter int unsigned V_FRONT_LINES = 10
) (
  input  logic       i_clk,
  input  logic       i_n_reset,
  input  logic       i_enable,
  input  logic       i_pattern_sel,
  output logic       o_pclk,
  output logic       o_vsync,
  output logic       o_href,
  output logic [7:0] o_data,
  output logic       o_frame_done
);

  localparam int unsigned LINE     = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned VS_TICKS = VSYNC_LINES * LINE;
  localparam int unsigned VB_TICKS = V_BACK_LINES * LINE;
  localparam int unsigned VF_TICKS = V_FRONT_LINES * LINE;
  localparam int unsigned CNT_MAX  = max2(max2(VS_TICKS, VB_TICKS), max2(VF_TICKS, LINE));
  localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned DIV_W    = $clog2(CLK_DIV);
  localparam int unsigned X_W      = $clog2(H_ACTIVE);
  localparam int unsigned Y_W      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  dvp_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [Y_W-1:0]   line_q, line_d;
  logic             sel_q, sel_d;
  logic             vsync_q, vsync_d;
  logic             href_q, href_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;

  logic             w_tick;
  logic             w_active_byte;
  logic [15:0]      w_pix;
  logic [7:0]       w_byte;

  always_ff @(posedge i_clk) begin
    if (!i_n_reset || !i_enable) begin
      div_q   <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      sel_q   <= 1'b0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      sel_q   <= sel_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // A tick is the PCLK falling edge; all frame timing advances only here.
  assign w_tick = (div_q == DIV_W'(CLK_DIV - 1));
  assign div_d  = w_tick ? '0 : div_q + DIV_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    if (w_tick) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_VSYNC;
          cnt_d   = '0;
          sel_d   = i_pattern_sel;
        end
        ST_VSYNC: begin
          if (cnt_q == CNT_W'(VS_TICKS - 1)) begin
            state_d = ST_VBACK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_VBACK: begin
          if (cnt_q == CNT_W'(VB_TICKS - 1)) begin
            state_d = ST_ACTIVE;
            cnt_d   = '0;
            line_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_ACTIVE: begin
          // cnt is the position within the line: bytes first, then blanking.
          if (cnt_q == CNT_W'(LINE - 1)) begin
            cnt_d = '0;
            if (line_q == Y_W'(V_ACTIVE - 1)) begin
              state_d = ST_VFRONT;
              line_d  = '0;
            end else begin
              line_d = line_q + Y_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_VFRONT: begin
          if (cnt_q == CNT_W'(VF_TICKS - 1)) begin
            state_d = ST_VSYNC;
            cnt_d   = '0;
            done_d  = 1'b1;
            sel_d   = i_pattern_sel;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          line_d  = '0;
        end
      endcase
    end
  end

  dvp_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_pattern (
    .x_i   (cnt_d[X_W:1]),
    .y_i   (line_d),
    .sel_i (sel_q),
    .pix_o (w_pix)
  );

  assign w_active_byte = (state_d == ST_ACTIVE) && (cnt_d < CNT_W'(2 * H_ACTIVE));
  assign w_byte        = cnt_d[0] ? w_pix[7:0] : w_pix[15:8];

  always_comb begin
    vsync_d = vsync_q;
    href_d  = href_q;
    data_d  = data_q;
    if (w_tick) begin
      vsync_d = (state_d == ST_VSYNC);
      href_d  = w_active_byte;
      data_d  = w_active_byte ? w_byte : 8'h00;
    end
  end

  assign o_pclk       = (div_q >= DIV_W'(CLK_DIV / 2));
  assign o_vsync      = vsync_q;
  assign o_href       = href_q;
  assign o_data       = data_q;
  assign o_frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_dvp_emulator.sv
`default_nettype none
// Self-checking bench for ov7670_dvp_emulator: small geometry timing, patterns,
// enable abort and pattern-select latching; default geometry for the reset check.
module tb_ov7670_dvp_emulator;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       enable;
  logic       sel;

  logic       s_pclk, s_vsync, s_href, s_done;
  logic [7:0] s_data;
  logic       d_pclk, d_vsync, d_href, d_done;
  logic [7:0] d_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ov7670_dvp_emulator #(
    .CLK_DIV(4), .H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(2),
    .VSYNC_LINES(1), .V_BACK_LINES(1), .V_FRONT_LINES(1)
  ) dut (
    .i_clk(clk), .i_n_reset(n_reset), .i_enable(enable), .i_pattern_sel(sel),
    .o_pclk(s_pclk), .o_vsync(s_vsync), .o_href(s_href), .o_data(s_data),
    .o_frame_done(s_done)
  );

  ov7670_dvp_emulator dut_def (
    .i_clk(clk), .i_n_reset(n_reset), .i_enable(enable), .i_pattern_sel(sel),
    .o_pclk(d_pclk), .o_vsync(d_vsync), .o_href(d_href), .o_data(d_data),
    .o_frame_done(d_done)
  );

  typedef struct {
    int         frame;
    logic       psel;
    int         idx;
    logic [7:0] exp;
  } vec_t;

  vec_t        vecs[64];
  logic [15:0] bars[8];
  logic [7:0]  cap[64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int vs_fall, nr, nf, nd, bad_edge, bad_blank;
    int hr_rise[4];
    int hr_fall[4];
    int done_at[4];
    int bcnt[2];
    logic p_vs, p_hr, p_pclk;
    logic [7:0] p_data;
    int wait_c;
    logic seen;

    bars[0] = 16'hFFFF; bars[1] = 16'hFFE0; bars[2] = 16'h07FF; bars[3] = 16'h07E0;
    bars[4] = 16'hF81F; bars[5] = 16'hF800; bars[6] = 16'h001F; bars[7] = 16'h0000;
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < 2; l++) begin
        for (int x = 0; x < 8; x++) begin
          for (int b = 0; b < 2; b++) begin
            logic [15:0] pix;
            int k;
            k = f * 32 + l * 16 + x * 2 + b;
            pix = (f == 0) ? bars[x] : {8'(l), 8'(x)};
            vecs[k].frame = f;
            vecs[k].psel  = (f == 1);
            vecs[k].idx   = l * 16 + x * 2 + b;
            vecs[k].exp   = (b == 1) ? pix[7:0] : pix[15:8];
          end
        end
      end
    end

    // Reset with enable high: everything held at zero.
    n_reset = 1'b0; enable = 1'b1; sel = 1'b0;
    repeat (5) begin
      step();
      check("reset_small", {s_pclk, s_vsync, s_href, s_data, s_done}, 0);
      check("reset_default", {d_pclk, d_vsync, d_href, d_data, d_done}, 0);
    end
    n_reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("vsync_start_small", s_vsync, (k == 4));
      check("vsync_start_default", d_vsync, (k == 4));
    end

    // Two full frames of the small geometry; sel changes mid-frame A.
    vs_fall = -1; nr = 0; nf = 0; nd = 0; bad_edge = 0; bad_blank = 0;
    bcnt[0] = 0; bcnt[1] = 0;
    p_vs = s_vsync; p_hr = s_href; p_pclk = s_pclk; p_data = s_data;
    for (int c = 1; c <= 900; c++) begin
      step();
      if (p_vs && !s_vsync && vs_fall < 0) vs_fall = c;
      if (!p_hr && s_href) begin if (nr < 4) hr_rise[nr] = c; nr++; end
      if (p_hr && !s_href) begin if (nf < 4) hr_fall[nf] = c; nf++; end
      if ((s_vsync != p_vs || s_href != p_hr || s_data != p_data) && !(p_pclk && !s_pclk))
        bad_edge++;
      if (!s_href && s_data != 8'h00) bad_blank++;
      if (s_pclk && !p_pclk && s_href && nd < 2 && bcnt[nd] < 32) begin
        cap[nd * 32 + bcnt[nd]] = s_data;
        bcnt[nd]++;
      end
      if (s_done) begin if (nd < 4) done_at[nd] = c; nd++; end
      p_vs = s_vsync; p_hr = s_href; p_pclk = s_pclk; p_data = s_data;
      if (c == 200) sel = 1'b1;
    end
    check("vsync_high_len", vs_fall, 80);
    check("href0_rise", hr_rise[0], 160);
    check("href0_fall", hr_fall[0], 224);
    check("href1_rise", hr_rise[1], 240);
    check("href1_fall", hr_fall[1], 304);
    check("frameB_href_rise", hr_rise[2], 560);
    check("done_count", nd, 2);
    check("done0_at", done_at[0], 400);
    check("done1_at", done_at[1], 800);
    check("change_off_pclk_fall", bad_edge, 0);
    check("data_in_blank", bad_blank, 0);
    check("bytes_frameA", bcnt[0], 32);
    check("bytes_frameB", bcnt[1], 32);

    for (int i = 0; i < 64; i++) begin
      check($sformatf("byte_f%0d_sel%0d_i%0d", vecs[i].frame, vecs[i].psel, vecs[i].idx),
            cap[vecs[i].frame * 32 + vecs[i].idx], vecs[i].exp);
    end

    // Abort mid-href by dropping enable for 10 cycles.
    seen = s_href;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      seen = s_href;
    end
    check("href_before_abort", seen, 1);
    repeat (5) step();
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("disabled_outputs", {s_pclk, s_vsync, s_href, s_data, s_done}, 0);
    end
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("vsync_restart", s_vsync, (k == 4));
    end
    wait_c = -1;
    for (int c = 1; c <= 500 && wait_c < 0; c++) begin
      step();
      if (s_done) wait_c = c;
    end
    check("first_done_after_restart", wait_c, 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ov7670_dvp_emulator.md
Name: ov7670_dvp_emulator

Overview:
Synthesizable OV7670 camera-side model: the sensor end of the XCLK/DVP interface our receiver consumes. Generates PCLK, VSYNC, HREF and 8-bit RGB565 byte data for a configurable frame geometry, with a built-in test pattern. Used in simulation and for on-board loopback into the OV7670 receiver when no camera is fitted. Gated by i_enable, in the same way the camera only runs while XCLK is supplied.

Parameters:
CLK_DIV, 4, i_clk cycles per PCLK period; even, >=2
H_ACTIVE, 640, active pixels per line (2 bytes each); multiple of 8
H_BLANK, 288, PCLK periods with HREF low after each active line
V_ACTIVE, 480, active lines per frame
VSYNC_LINES, 3, line times with VSYNC high
V_BACK_LINES, 17, line times between VSYNC fall and first HREF
V_FRONT_LINES, 10, line times after last active line

Ports:
i_clk  in  1  system clock
i_n_reset  in  1  synchronous, active-low reset
i_enable  in  1  run enable; low equals soft reset
i_pattern_sel  in  1  0 = colour bars, 1 = coordinate pattern; sampled at frame start
o_pclk  out  1  pixel clock, 50% duty
o_vsync  out  1  frame sync, active high
o_href  out  1  line valid, active high
o_data  out  8  pixel byte, RGB565 high byte first
o_frame_done  out  1  one-i_clk pulse at end of each frame

Behaviour:
- Reset and clock: one clock, i_clk. Reset is synchronous and active-low on i_n_reset. In reset, or while i_enable=0: all outputs 0, divider 0, FSM in IDLE, counters 0. Effect is seen on the next edge. Deasserting i_enable mid-frame aborts the frame with no frame_done.
- Divider: r_div counts 0..CLK_DIV-1 and wraps. o_pclk = 1 when r_div >= CLK_DIV/2, else 0.
- Tick: a "tick" is the cycle in which r_div wraps CLK_DIV-1 -> 0, i.e. the PCLK falling edge. o_vsync, o_href and o_data change only on ticks, so they are stable half a period before each PCLK rising edge.
- LINE = 2*H_ACTIVE + H_BLANK PCLK periods.
- FSM, advancing one step per tick:
  - IDLE -> VSYNC on the first tick after enable. o_vsync rises CLK_DIV cycles after i_enable is first sampled high. i_pattern_sel is latched here.
  - VSYNC (vsync=1) lasts VSYNC_LINES*LINE ticks, then goes to VBACK.
  - VBACK lasts V_BACK_LINES*LINE ticks, then goes to ACTIVE.
  - ACTIVE runs V_ACTIVE lines. Each line is href=1 for 2*H_ACTIVE ticks, then href=0 for H_BLANK ticks. After the last line's blank, go to VFRONT.
  - VFRONT lasts V_FRONT_LINES*LINE ticks, then goes to VSYNC. On this transition: o_frame_done=1 for exactly one i_clk cycle, and i_pattern_sel is re-latched. Frames run continuously.
- Pixel counters: x (0..H_ACTIVE-1) and y (0..V_ACTIVE-1). The byte phase toggles every href tick. x increments after the second byte; y increments at end of line. Both wrap to 0.
- Bytes: byte0 = pix[15:8], byte1 = pix[7:0]. o_data = 0 whenever href = 0.
- Pattern 0: 8 equal vertical bars, bar = x / (H_ACTIVE/8). Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Pattern 1: pix = {y[7:0], x[7:0]}.
- Counter widths: $clog2 of the largest count. No overflow permitted by the parameter ranges.

Decomposition:
- Package ov7670_dvp_pkg: FSM state encoding (IDLE, VSYNC, VBACK, ACTIVE, VFRONT) and the 8 RGB565 bar constants.
- Sub-module dvp_pattern_gen: combinational x, y, sel -> 16-bit pix.

Test Plan:
All scenarios except 1 use small geometry: CLK_DIV=4, H_ACTIVE=8, H_BLANK=4, V_ACTIVE=2, VSYNC/VBACK/VFRONT_LINES=1. This gives LINE=20 PCLK and a frame of 100 PCLK = 400 i_clk.

1. Reset: i_n_reset=0 for 5 cycles with i_enable=1 and default geometry -> every output 0; o_vsync rises 4 cycles after reset release.
2. Timing -> vsync high exactly 80 i_clk; first href rises 80 i_clk after vsync falls; 2 href pulses per frame of 64 i_clk each, spaced 16 i_clk low; frame_done every 400 i_clk; all output changes coincide with o_pclk falling.
3. Colour bars (sel=0) -> line bytes FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00; o_data=00 during blank.
4. Coordinate pattern (sel=1) -> second line bytes 01 00, 01 01, ..., 01 07.
5. Drop i_enable mid-href for 10 cycles, then raise it -> outputs 0 on the next edge; vsync rises 4 cycles after re-enable; no frame_done for the aborted frame.
6. Toggle i_pattern_sel mid-frame -> current frame's pattern is unchanged; the new pattern applies from the frame after the next frame_done.
